// File: rtl/tlc_bus_master.sv
// Bus initiator for the traffic-light controller register port: writes boot values
// after reset, then serves single host read/write commands with a bounded bus wait.
module tlc_bus_master #(
  parameter logic [31:0] RED_INIT  = 32'h0064_001E,
  parameter logic [31:0] YEL_INIT  = 32'h001E_0005,
  parameter logic [31:0] GRN_INIT  = 32'h0050_0019,
  parameter logic [31:0] MODE_INIT = 32'h0000_0004,
  parameter bit          AUTO_INIT = 1'b1,
  parameter int          TIMEOUT   = 16
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done,
  output logic        init_err,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pvalid,
  output logic        prd_wr,
  input  logic [31:0] prdata,
  input  logic        pready
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_BOOT, S_ACCESS, S_RESP, S_IDLE} state_t;

  state_t          state;
  logic [1:0]      boot_idx;
  logic            boot_phase;
  logic [TW-1:0]   tcnt;

  function automatic logic [31:0] boot_data(input logic [1:0] idx);
    case (idx)
      2'd0:    boot_data = RED_INIT;
      2'd1:    boot_data = YEL_INIT;
      2'd2:    boot_data = GRN_INIT;
      default: boot_data = MODE_INIT;
    endcase
  endfunction

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state      <= S_BOOT;
      boot_idx   <= 2'd0;
      boot_phase <= 1'b0;
      tcnt       <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      paddr      <= 32'd0;
      pwdata     <= 32'd0;
      pvalid     <= 1'b0;
      prd_wr     <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          if (!AUTO_INIT) begin
            init_done <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            paddr      <= {24'd0, 4'd0, boot_idx, 2'b00};
            pwdata     <= boot_data(boot_idx);
            prd_wr     <= 1'b1;
            pvalid     <= 1'b1;
            boot_phase <= 1'b1;
            tcnt       <= '0;
            state      <= S_ACCESS;
          end
        end

        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_addr[1:0] != 2'b00) begin
              // misaligned: answer with an error without touching the bus
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
              state     <= S_RESP;
            end else begin
              paddr      <= {24'd0, cmd_addr};
              pwdata     <= cmd_wr ? cmd_wdata : 32'd0;
              prd_wr     <= cmd_wr;
              pvalid     <= 1'b1;
              boot_phase <= 1'b0;
              tcnt       <= '0;
              state      <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          // pready is checked first so a completion on the timeout cycle still wins
          if (pready) begin
            pvalid <= 1'b0;
            prd_wr <= 1'b0;
            tcnt   <= '0;
            if (boot_phase) begin
              if (boot_idx == 2'd3) begin
                init_done <= 1'b1;
                cmd_ready <= 1'b1;
                state     <= S_IDLE;
              end else begin
                boot_idx <= boot_idx + 2'd1;
                state    <= S_BOOT;
              end
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= prd_wr ? 32'd0 : prdata;
              state     <= S_RESP;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            pvalid <= 1'b0;
            prd_wr <= 1'b0;
            tcnt   <= '0;
            if (boot_phase) begin
              init_err  <= 1'b1;
              init_done <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
              state     <= S_RESP;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'd0;
          cmd_ready <= init_done;
          state     <= S_IDLE;
        end

        default: state <= S_BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_tlc_bus_master.sv
// Directed bench for tlc_bus_master: boot writes, reads/writes, wait states,
// timeouts (bus and boot), misaligned address and reset mid-transfer.
module tb_tlc_bus_master;
  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err, init_done, init_err;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        pvalid, prd_wr, pready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  tlc_bus_master dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done), .init_err(init_err),
    .paddr(paddr), .pwdata(pwdata), .pvalid(pvalid), .prd_wr(prd_wr),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_pvalid(input string tag);
    int n = 0;
    while (!pvalid && n < 10) begin
      tick();
      n++;
    end
    check(tag, {31'd0, pvalid}, 32'd1);
  endtask

  initial begin
    logic [31:0] bexp [4];
    int n;
    int rsp_cnt;
    bexp[0] = 32'h0064_001E;
    bexp[1] = 32'h001E_0005;
    bexp[2] = 32'h0050_0019;
    bexp[3] = 32'h0000_0004;

    prst = 1'b0; pready = 1'b0; prdata = 32'd0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'd0; cmd_wdata = 32'd0;
    tick(); tick();
    check("rst pvalid", {31'd0, pvalid}, 32'd0);
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst init_done", {31'd0, init_done}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst paddr", paddr, 32'd0);

    // 1: boot sequence with pready tied high
    pready = 1'b1;
    prst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_pvalid("boot pvalid");
      check("boot paddr", paddr, 32'(i * 4));
      check("boot pwdata", pwdata, bexp[i]);
      check("boot prd_wr", {31'd0, prd_wr}, 32'd1);
      check("boot init_done low", {31'd0, init_done}, 32'd0);
      check("boot no rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check("boot init_done", {31'd0, init_done}, 32'd1);
    check("boot init_err", {31'd0, init_err}, 32'd0);
    check("boot pvalid off", {31'd0, pvalid}, 32'd0);
    check("boot cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("boot rsp after", {31'd0, rsp_valid}, 32'd0);

    // 2: read 0x04 with two wait states
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h04; cmd_wdata = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    check("rd pvalid", {31'd0, pvalid}, 32'd1);
    check("rd paddr", paddr, 32'h4);
    check("rd pwdata zero", pwdata, 32'd0);
    check("rd prd_wr", {31'd0, prd_wr}, 32'd0);
    check("rd cmd_ready busy", {31'd0, cmd_ready}, 32'd0);
    tick();
    check("rd wait1 pvalid", {31'd0, pvalid}, 32'd1);
    tick();
    check("rd wait2 pvalid", {31'd0, pvalid}, 32'd1);
    check("rd wait2 rsp", {31'd0, rsp_valid}, 32'd0);
    pready = 1'b1; prdata = 32'h001E_0005;
    tick();
    pready = 1'b0; prdata = 32'd0;
    check("rd pvalid off", {31'd0, pvalid}, 32'd0);
    check("rd rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd rsp_rdata", rsp_rdata, 32'h001E_0005);
    check("rd rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();
    check("rd rsp pulse end", {31'd0, rsp_valid}, 32'd0);
    check("rd ready again", {31'd0, cmd_ready}, 32'd1);

    // 3: back-to-back writes to 0x0C
    pready = 1'b1;
    rsp_cnt = 0;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h0C; cmd_wdata = 32'h3;
    tick();
    cmd_wdata = 32'h1;
    check("wr1 pvalid", {31'd0, pvalid}, 32'd1);
    check("wr1 pwdata", pwdata, 32'h3);
    check("wr1 prd_wr", {31'd0, prd_wr}, 32'd1);
    tick();
    rsp_cnt += int'(rsp_valid);
    check("wr1 rsp_rdata", rsp_rdata, 32'd0);
    check("wr1 gap pvalid", {31'd0, pvalid}, 32'd0);
    tick();
    check("wr gap2 pvalid", {31'd0, pvalid}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("wr2 pvalid", {31'd0, pvalid}, 32'd1);
    check("wr2 pwdata", pwdata, 32'h1);
    tick();
    rsp_cnt += int'(rsp_valid);
    check("wr rsp count", 32'(rsp_cnt), 32'd2);
    tick();

    // 4: bus timeout, then a normal command
    pready = 1'b0; prdata = 32'h1234_5678;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h08;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (pvalid && n < 40) begin
      n++;
      tick();
    end
    check("to pvalid cycles", 32'(n), 32'd16);
    check("to rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to rsp_rdata", rsp_rdata, 32'd0);
    tick();
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'h0000_ABCD;
    tick();
    cmd_valid = 1'b0;
    check("post-to paddr", paddr, 32'h10);
    tick();
    check("post-to rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("post-to rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();

    // pready on the timeout cycle completes normally
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h00;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("edge pvalid still", {31'd0, pvalid}, 32'd1);
    pready = 1'b1; prdata = 32'hCAFE_0001;
    tick();
    pready = 1'b0;
    check("edge rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("edge rsp_err", {31'd0, rsp_err}, 32'd0);
    check("edge rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    tick();

    // 5: misaligned address
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h06;
    tick();
    cmd_valid = 1'b0;
    check("mis pvalid", {31'd0, pvalid}, 32'd0);
    check("mis rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("mis rsp_err", {31'd0, rsp_err}, 32'd1);
    tick();
    check("mis rsp end", {31'd0, rsp_valid}, 32'd0);

    // 5b: boot timeout
    prst = 1'b0;
    tick();
    prst = 1'b1;
    wait_pvalid("bto pvalid");
    check("bto paddr", paddr, 32'h0);
    n = 0;
    while (pvalid && n < 40) begin
      n++;
      tick();
    end
    check("bto pvalid cycles", 32'(n), 32'd16);
    check("bto init_err", {31'd0, init_err}, 32'd1);
    check("bto init_done", {31'd0, init_done}, 32'd1);
    check("bto no rsp", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("bto abandoned", {31'd0, pvalid}, 32'd0);

    // 6: reset mid-transfer
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h08;
    tick();
    cmd_valid = 1'b0;
    check("rstmid pvalid", {31'd0, pvalid}, 32'd1);
    prst = 1'b0;
    #1;
    check("rstmid pvalid drop", {31'd0, pvalid}, 32'd0);
    check("rstmid init_done", {31'd0, init_done}, 32'd0);
    check("rstmid init_err", {31'd0, init_err}, 32'd0);
    tick();
    prst = 1'b1; pready = 1'b1;
    wait_pvalid("reboot pvalid");
    check("reboot paddr", paddr, 32'h0);
    check("reboot pwdata", pwdata, 32'h0064_001E);
    check("reboot prd_wr", {31'd0, prd_wr}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
